// File: rtl/arith_arbiter.sv
// Round-robin arbiter giving NREQ requesters turns on one shared combinational adder.
// Each operation takes IDLE -> EXEC -> DONE; done/gnt are decoded from the DONE state.
module arith_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] a_in,
   input  logic [NREQ*WIDTH-1:0] b_in,
   output logic [WIDTH-1:0]      arith_a,
   output logic [WIDTH-1:0]      arith_b,
   input  logic [WIDTH-1:0]      arith_out,
   output logic [WIDTH-1:0]      result,
   output logic [NREQ-1:0]       gnt,
   output logic                  done,
   output logic                  busy
);

   localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [IDXW-1:0] winner;
   logic [IDXW-1:0] winner_next;
   logic [IDXW-1:0] last;
   logic            found;
   logic [WIDTH-1:0] a_sel;
   logic [WIDTH-1:0] b_sel;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: every signal driven in always_comb gets a default first, otherwise a latch is inferred.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (|req) state_next = EXEC;
         EXEC:    state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Search starts just after the last served requester, so the previous winner has lowest priority.
   always_comb begin
      winner_next = '0;
      found       = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!found && req[(int'(last) + k) % NREQ]) begin
            found       = 1'b1;
            winner_next = IDXW'((int'(last) + k) % NREQ);
         end
      end
   end

   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (winner_next == IDXW'(i)) begin
            a_sel = a_in[i*WIDTH +: WIDTH];
            b_sel = b_in[i*WIDTH +: WIDTH];
         end
      end
   end

   // Operands are captured only on the IDLE->EXEC edge, so later input changes cannot disturb the operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arith_a <= '0;
         arith_b <= '0;
         result  <= '0;
         winner  <= '0;
         last    <= IDXW'(NREQ - 1);
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  arith_a <= a_sel;
                  arith_b <= b_sel;
                  winner  <= winner_next;
               end
            end
            EXEC: begin
               result <= arith_out;
               last   <= winner;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
      gnt  = '0;
      if (state == DONE) gnt[last] = 1'b1;
   end

endmodule
